video_write_scheduler: RTL and testbench

- Sole writer of the 160x120 video memory write port (15-bit address, 3-bit colour, write enable) inside the VGA controller.
- Arbitrates between two sources: a single-pixel port driven by the CPU/renderer, and an internal rectangle-fill sequencer.
- Issues at most one memory write per clock, round-robin between sources.
- Runs on the 48 MHz system clock, the same clock as the video memory write side.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/video_write_scheduler_rect_walker.sv | 80 ++++++++
 rtl/video_write_scheduler.sv | 135 +++++++++++++
 tb/tb_video_write_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and enumerations for the VGA controller's video memory write side.
package vga_pkg;

    localparam int unsigned H_RES  = 160;
    localparam int unsigned V_RES  = 120;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned RGB_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef enum logic {
        SRC_PIX,
        SRC_FILL
    } grant_src_e;

endpackage

// File: rtl/video_write_scheduler_rect_walker.sv
// Rectangle cursor: clips and latches fill bounds, then walks row-major one pixel per step.
module rect_walker #(
    parameter int unsigned H_RES = vga_pkg::H_RES,
    parameter int unsigned V_RES = vga_pkg::V_RES,
    parameter int unsigned RGB_W = vga_pkg::RGB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [7:0]       x0_i,
    input  logic [7:0]       x1_i,
    input  logic [6:0]       y0_i,
    input  logic [6:0]       y1_i,
    input  logic [RGB_W-1:0] rgb_i,
    output logic             empty_o,
    output logic [7:0]       cx_o,
    output logic [6:0]       cy_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             last_o
);
    import vga_pkg::*;

    localparam logic [7:0] X_MAX = 8'(H_RES - 1);
    localparam logic [6:0] Y_MAX = 7'(V_RES - 1);

    logic [7:0]       x0_q, x1_q, cx_q, cx_d;
    logic [6:0]       y1_q, cy_q, cy_d;
    logic [RGB_W-1:0] rgb_q;
    logic [7:0]       x1_clip;
    logic [6:0]       y1_clip;

    always_comb begin
        x1_clip = (x1_i > X_MAX) ? X_MAX : x1_i;
        y1_clip = (y1_i > Y_MAX) ? Y_MAX : y1_i;
        // x0/y0 beyond the screen can never be drawn, so they count as empty too
        empty_o = (x0_i > X_MAX) || (y0_i > Y_MAX) ||
                  (x0_i > x1_clip) || (y0_i > y1_clip);
    end

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (step_i) begin
            if (cx_q == x1_q) begin
                cx_d = x0_q;
                cy_d = cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0_q  <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
            cx_q  <= '0;
            cy_q  <= '0;
            rgb_q <= '0;
        end else if (load_i) begin
            x0_q  <= x0_i;
            x1_q  <= x1_clip;
            y1_q  <= y1_clip;
            cx_q  <= x0_i;
            cy_q  <= y0_i;
            rgb_q <= rgb_i;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign rgb_o  = rgb_q;
    assign last_o = (cx_q == x1_q) && (cy_q == y1_q);

endmodule

// File: rtl/video_write_scheduler.sv
// Sole writer of the video memory: round-robin between the pixel port and the rectangle fill.
module video_write_scheduler #(
    parameter int unsigned H_RES  = vga_pkg::H_RES,
    parameter int unsigned V_RES  = vga_pkg::V_RES,
    parameter int unsigned ADDR_W = vga_pkg::ADDR_W,
    parameter int unsigned RGB_W  = vga_pkg::RGB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_x,
    input  logic [6:0]        pix_y,
    input  logic [RGB_W-1:0]  pix_rgb,
    input  logic              fill_start,
    input  logic [7:0]        fill_x0,
    input  logic [7:0]        fill_x1,
    input  logic [6:0]        fill_y0,
    input  logic [6:0]        fill_y1,
    input  logic [RGB_W-1:0]  fill_rgb,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [RGB_W-1:0]  mem_data,
    output logic              mem_we
);
    import vga_pkg::*;

    localparam logic [7:0] X_MAX = 8'(H_RES - 1);
    localparam logic [6:0] Y_MAX = 7'(V_RES - 1);

    fill_state_e       state_q;
    grant_src_e        last_grant_q;
    logic              fill_busy_q, fill_done_q;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [RGB_W-1:0]  mem_data_q, mem_data_d;

    logic              fill_req, pix_win, fill_win, fill_load;
    logic              walk_empty, walk_last;
    logic [7:0]        walk_cx, sel_x;
    logic [6:0]        walk_cy, sel_y;
    logic [RGB_W-1:0]  walk_rgb;

    rect_walker #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .RGB_W (RGB_W)
    ) u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (fill_load),
        .step_i  (fill_win),
        .x0_i    (fill_x0),
        .x1_i    (fill_x1),
        .y0_i    (fill_y0),
        .y1_i    (fill_y1),
        .rgb_i   (fill_rgb),
        .empty_o (walk_empty),
        .cx_o    (walk_cx),
        .cy_o    (walk_cy),
        .rgb_o   (walk_rgb),
        .last_o  (walk_last)
    );

    always_comb begin
        fill_req  = (state_q == FILL);
        pix_win   = pix_valid && (!fill_req || last_grant_q == SRC_FILL);
        fill_win  = fill_req && !pix_win;
        pix_ready = rst_n && (!fill_req || last_grant_q == SRC_FILL);
        fill_load = fill_start && (state_q == IDLE) && !walk_empty;

        sel_x      = pix_win ? pix_x : walk_cx;
        sel_y      = pix_win ? pix_y : walk_cy;
        mem_data_d = pix_win ? pix_rgb : walk_rgb;
        mem_addr_d = ADDR_W'(sel_y) * ADDR_W'(H_RES) + ADDR_W'(sel_x);
        // off-screen pixels still consume their grant but never reach memory
        mem_we_d   = pix_win ? ((pix_x <= X_MAX) && (pix_y <= Y_MAX)) : fill_win;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_FILL;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            mem_we_q <= mem_we_d;
            if (pix_win || fill_win) begin
                mem_addr_q   <= mem_addr_d;
                mem_data_q   <= mem_data_d;
                last_grant_q <= pix_win ? SRC_PIX : SRC_FILL;
            end
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        if (walk_empty) begin
                            state_q     <= DONE;
                            fill_done_q <= 1'b1;
                        end else begin
                            state_q     <= FILL;
                            fill_busy_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_win && walk_last) begin
                        state_q     <= DONE;
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    fill_done_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    fill_busy_q <= 1'b0;
                    fill_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_video_write_scheduler.sv
// Directed bench for video_write_scheduler with hand-computed expected write streams.
module tb_video_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_rgb;
    logic        fill_start;
    logic [7:0]  fill_x0, fill_x1;
    logic [6:0]  fill_y0, fill_y1;
    logic [2:0]  fill_rgb;
    logic        fill_busy, fill_done;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    video_write_scheduler #(
        .H_RES  (160),
        .V_RES  (120),
        .ADDR_W (15),
        .RGB_W  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_x1    (fill_x1),
        .fill_y0    (fill_y0),
        .fill_y1    (fill_y1),
        .fill_rgb   (fill_rgb),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_fill(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [6:0] y0, input logic [6:0] y1,
                              input logic [2:0] rgb);
        fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_rgb = rgb;
        fill_start = 1'b1;
    endtask

    initial begin
        int unsigned exp_a[6];
        int writes;
        int first_a;
        int last_a;
        logic seen_done;

        exp_a = '{162, 163, 164, 322, 323, 324};

        rst_n = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0;
        fill_start = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_rgb = '0;

        // reset state
        tick(); tick();
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_we",        32'(mem_we), 0);
        check("rst_addr",      32'(mem_addr), 0);
        check("rst_data",      32'(mem_data), 0);
        check("rst_busy",      32'(fill_busy), 0);
        check("rst_done",      32'(fill_done), 0);
        rst_n = 1'b1;
        tick();
        check("idle_pix_ready", 32'(pix_ready), 1);

        // single pixel
        pix_valid = 1'b1; pix_x = 8'd10; pix_y = 7'd5; pix_rgb = 3'b101;
        #1;
        check("pix_ready", 32'(pix_ready), 1);
        tick();
        pix_valid = 1'b0;
        check("pix_we",   32'(mem_we), 1);
        check("pix_addr", 32'(mem_addr), 810);
        check("pix_data", 32'(mem_data), 5);
        tick();
        check("pix_we_off", 32'(mem_we), 0);

        // plain fill (2,1)-(4,2)
        start_fill(8'd2, 8'd4, 7'd1, 7'd2, 3'b010);
        tick();
        fill_start = 1'b0;
        check("fill_busy_start", 32'(fill_busy), 1);
        check("fill_we_latency", 32'(mem_we), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("fill_we%0d", i),   32'(mem_we), 1);
            check($sformatf("fill_addr%0d", i), 32'(mem_addr), exp_a[i]);
            check($sformatf("fill_data%0d", i), 32'(mem_data), 2);
            check($sformatf("fill_busy%0d", i), 32'(fill_busy), (i < 5) ? 1 : 0);
            check($sformatf("fill_done%0d", i), 32'(fill_done), (i == 5) ? 1 : 0);
        end
        tick();
        check("fill_done_pulse", 32'(fill_done), 0);
        check("fill_idle_we",    32'(mem_we), 0);

        // contention: pixel and fill alternate, pixel first
        pix_valid = 1'b1; pix_x = 8'd159; pix_y = 7'd119; pix_rgb = 3'd7;
        start_fill(8'd0, 8'd3, 7'd0, 7'd0, 3'd1);
        #1;
        check("cont_ready0", 32'(pix_ready), 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            fill_start = 1'b0;
            check($sformatf("cont_addr%0d", k), 32'(mem_addr), (k % 2 == 0) ? 19199 : k / 2);
            check($sformatf("cont_data%0d", k), 32'(mem_data), (k % 2 == 0) ? 7 : 1);
            check($sformatf("cont_we%0d", k),   32'(mem_we), 1);
            check($sformatf("cont_ready%0d", k + 1), 32'(pix_ready),
                  (k == 7 || k % 2 == 1) ? 1 : 0);
            check($sformatf("cont_done%0d", k), 32'(fill_done), (k == 7) ? 1 : 0);
        end
        pix_valid = 1'b0;
        tick();
        check("cont_we_off",   32'(mem_we), 0);
        check("cont_done_off", 32'(fill_done), 0);

        // clipped fill: (150,115)-(255,127) -> 10x5
        start_fill(8'd150, 8'd255, 7'd115, 7'd127, 3'd4);
        tick();
        fill_start = 1'b0;
        writes = 0; first_a = -1; last_a = -1; seen_done = 1'b0;
        for (int i = 0; i < 100 && !seen_done; i++) begin
            tick();
            if (mem_we) begin
                if (first_a < 0) first_a = int'(mem_addr);
                last_a = int'(mem_addr);
                writes++;
            end
            if (fill_done) seen_done = 1'b1;
        end
        check("clip_done_seen", 32'(seen_done), 1);
        check("clip_writes",    32'(writes), 50);
        check("clip_first",     32'(first_a), 18550);
        check("clip_last",      32'(last_a), 19199);

        // empty rectangle x0 > x1
        tick();
        start_fill(8'd5, 8'd4, 7'd5, 7'd9, 3'd3);
        tick();
        fill_start = 1'b0;
        check("empty_done", 32'(fill_done), 1);
        check("empty_busy", 32'(fill_busy), 0);
        check("empty_we",   32'(mem_we), 0);
        tick();
        check("empty_done_off", 32'(fill_done), 0);
        check("empty_we2",      32'(mem_we), 0);

        // empty rectangle x0 off-screen
        start_fill(8'd200, 8'd210, 7'd0, 7'd3, 3'd3);
        tick();
        fill_start = 1'b0;
        check("offx_done", 32'(fill_done), 1);
        check("offx_we",   32'(mem_we), 0);
        tick();
        check("offx_we2", 32'(mem_we), 0);

        // out-of-range pixel: handshake completes, no write
        pix_valid = 1'b1; pix_x = 8'd160; pix_y = 7'd0; pix_rgb = 3'd6;
        #1;
        check("oor_ready", 32'(pix_ready), 1);
        tick();
        pix_valid = 1'b0;
        check("oor_we", 32'(mem_we), 0);

        // reset during a 100-pixel fill
        start_fill(8'd0, 8'd99, 7'd0, 7'd0, 3'd5);
        tick();
        fill_start = 1'b0;
        tick();
        tick();
        check("abort_pre_we",   32'(mem_we), 1);
        check("abort_pre_addr", 32'(mem_addr), 1);
        rst_n = 1'b0;
        tick();
        check("abort_we",    32'(mem_we), 0);
        check("abort_busy",  32'(fill_busy), 0);
        check("abort_done",  32'(fill_done), 0);
        check("abort_ready", 32'(pix_ready), 0);
        rst_n = 1'b1;
        seen_done = 1'b0; writes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fill_done) seen_done = 1'b1;
            if (mem_we) writes++;
        end
        check("abort_no_done",   32'(seen_done), 0);
        check("abort_no_writes", 32'(writes), 0);

        start_fill(8'd7, 8'd8, 7'd3, 7'd3, 3'd2);
        tick();
        fill_start = 1'b0;
        tick();
        check("refill_addr0", 32'(mem_addr), 487);
        check("refill_we0",   32'(mem_we), 1);
        tick();
        check("refill_addr1", 32'(mem_addr), 488);
        check("refill_done",  32'(fill_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
